// File: rtl/sap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sap_pkg
// Description : Shared constants for the SAP datapath: default widths, control
//               word bit positions, idle control word and opcode encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package sap_pkg;

    localparam int c_DATA_W_DEF = 8;
    localparam int c_ADDR_W_DEF = 4;

    // Control word layout, bit 14 down to bit 0
    localparam int c_CTRL_W          = 15;
    localparam int c_PC_INC          = 14;
    localparam int c_PC_EN           = 13;
    localparam int c_PC_LOAD         = 12;
    localparam int c_MAR_ADDR_LOAD_N = 11;
    localparam int c_MAR_MEM_LOAD_N  = 10;
    localparam int c_RAM_EN_N        = 9;
    localparam int c_RAM_LOAD_N      = 8;
    localparam int c_IR_LOAD_N       = 7;
    localparam int c_IR_EN_N         = 6;
    localparam int c_REGA_LOAD_N     = 5;
    localparam int c_REGA_EN         = 4;
    localparam int c_ADDER_SUB       = 3;
    localparam int c_REGB_EN         = 2;
    localparam int c_REGB_LOAD_N     = 1;
    localparam int c_OUT_LOAD_N      = 0;

    // Every strobe inactive: active-low bits high, active-high bits low
    localparam logic [c_CTRL_W-1:0] c_CTRL_IDLE = 15'b000_1111_1110_0011;

    // Number of sources that can drive the shared bus
    localparam int c_NUM_DRV = 5;

    typedef enum logic [3:0] {
        c_OP_HLT = 4'd0,
        c_OP_NOP = 4'd1,
        c_OP_ADD = 4'd2,
        c_OP_SUB = 4'd3,
        c_OP_LDA = 4'd4,
        c_OP_OUT = 4'd5,
        c_OP_STA = 4'd6,
        c_OP_JMP = 4'd7
    } sap_opcode_e;

    // True when two or more bus drivers are enabled at once
    function automatic logic multi_drive(input logic [c_NUM_DRV-1:0] drv);
        int cnt;
        cnt = 0;
        for (int i = 0; i < c_NUM_DRV; i++) begin
            cnt = cnt + int'(drv[i]);
        end
        return (cnt > 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sap_ram16x8.sv
`default_nettype none
// ============================================================================
// Module      : sap_ram16x8
// Description : Program/data RAM, asynchronous read, synchronous write. The
//               write port is shared between the datapath and the external
//               programming port, selected by i_prog_en.
// Revision    : 1.0 - initial release
// ============================================================================
module sap_ram16x8 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_prog_en,
    input  logic              i_prog_we,
    input  logic [ADDR_W-1:0] i_prog_addr,
    input  logic [DATA_W-1:0] i_prog_data,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    // Select the write source: programming port owns the RAM while i_prog_en is high
    always_comb begin
        w_we    = i_we;
        w_waddr = i_addr;
        w_wdata = i_wdata;
        if (i_prog_en) begin
            w_we    = i_prog_we;
            w_waddr = i_prog_addr;
            w_wdata = i_prog_data;
        end
    end

    // Contents survive reset; an edge taken while reset is held writes nothing
    always_ff @(posedge clk) begin
        if (!rst && w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/sap_datapath.sv
`default_nettype none
// ============================================================================
// Module      : sap_datapath
// Description : SAP-1 style datapath: shared bus, PC, MAR, MDR, IR, A, B,
//               adder/subtractor with flags, output register and RAM.
//               Driven by a 15-bit control word from an external sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module sap_datapath
    import sap_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEF,
    parameter int ADDR_W = c_ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [c_CTRL_W-1:0] ctrl,
    input  logic                prog_en,
    input  logic                prog_we,
    input  logic [ADDR_W-1:0]   prog_addr,
    input  logic [DATA_W-1:0]   prog_data,
    output logic [3:0]          opcode,
    output logic [DATA_W-1:0]   out_val,
    output logic                out_valid,
    output logic                carry,
    output logic                zero,
    output logic                bus_conflict
);

    logic [c_CTRL_W-1:0] w_ctrl;
    logic w_pc_inc, w_pc_en, w_pc_ld, w_mar_ld, w_mdr_ld, w_ram_en, w_ram_ld;
    logic w_ir_ld, w_ir_en, w_a_ld, w_a_en, w_sub, w_b_en, w_b_ld, w_out_ld;

    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    r_mar;
    logic [DATA_W-1:0]    r_mdr;
    logic [DATA_W-1:0]    r_ir;
    logic [DATA_W-1:0]    r_a;
    logic [DATA_W-1:0]    r_b;
    logic [DATA_W-1:0]    r_out;
    logic                 r_out_valid;
    logic                 r_carry;
    logic                 r_zero;
    logic                 r_conflict;

    logic [DATA_W-1:0]    w_bus;
    logic [DATA_W-1:0]    w_ram_rdata;
    logic [DATA_W:0]      w_alu_full;
    logic [DATA_W-1:0]    w_alu;
    logic                 w_alu_c;
    logic [c_NUM_DRV-1:0] w_drv;

    // While programming, the sequencer is ignored: no loads, no drivers
    assign w_ctrl = prog_en ? c_CTRL_IDLE : ctrl;

    assign w_pc_inc =  w_ctrl[c_PC_INC];
    assign w_pc_en  =  w_ctrl[c_PC_EN];
    assign w_pc_ld  =  w_ctrl[c_PC_LOAD];
    assign w_mar_ld = ~w_ctrl[c_MAR_ADDR_LOAD_N];
    assign w_mdr_ld = ~w_ctrl[c_MAR_MEM_LOAD_N];
    assign w_ram_en = ~w_ctrl[c_RAM_EN_N];
    assign w_ram_ld = ~w_ctrl[c_RAM_LOAD_N];
    assign w_ir_ld  = ~w_ctrl[c_IR_LOAD_N];
    assign w_ir_en  = ~w_ctrl[c_IR_EN_N];
    assign w_a_ld   = ~w_ctrl[c_REGA_LOAD_N];
    assign w_a_en   =  w_ctrl[c_REGA_EN];
    assign w_sub    =  w_ctrl[c_ADDER_SUB];
    assign w_b_en   =  w_ctrl[c_REGB_EN];
    assign w_b_ld   = ~w_ctrl[c_REGB_LOAD_N];
    assign w_out_ld = ~w_ctrl[c_OUT_LOAD_N];

    assign w_drv = {w_pc_en, w_ram_en, w_ir_en, w_a_en, w_b_en};

    // Adder/subtractor; subtract is A + ~B + 1 so carry-out means "no borrow"
    always_comb begin
        if (w_sub) begin
            w_alu_full = {1'b0, r_a} + {1'b0, ~r_b} + (DATA_W+1)'(1);
        end else begin
            w_alu_full = {1'b0, r_a} + {1'b0, r_b};
        end
    end

    assign w_alu   = w_alu_full[DATA_W-1:0];
    assign w_alu_c = w_alu_full[DATA_W];

    // Bus mux with fixed priority; an undriven bus reads as zero
    always_comb begin
        w_bus = '0;
        if (w_pc_en) begin
            w_bus = DATA_W'(r_pc);
        end else if (w_ram_en) begin
            w_bus = w_ram_rdata;
        end else if (w_ir_en) begin
            w_bus = DATA_W'(r_ir[ADDR_W-1:0]);
        end else if (w_a_en) begin
            w_bus = r_a;
        end else if (w_b_en) begin
            w_bus = w_alu;
        end
    end

    // Program counter: a load from the bus takes precedence over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
        end else if (w_pc_ld) begin
            r_pc <= w_bus[ADDR_W-1:0];
        end else if (w_pc_inc) begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    // Bus-loaded registers and the output strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mar       <= '0;
            r_mdr       <= '0;
            r_ir        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_mar_ld) r_mar <= w_bus[ADDR_W-1:0];
            if (w_mdr_ld) r_mdr <= w_bus;
            if (w_ir_ld)  r_ir  <= w_bus;
            if (w_a_ld)   r_a   <= w_bus;
            if (w_b_ld)   r_b   <= w_bus;
            if (w_out_ld) r_out <= w_bus;
            r_out_valid <= w_out_ld;
        end
    end

    // Flags capture only when the ALU result is written back into A
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_b_en && w_a_ld) begin
            r_carry <= w_alu_c;
            r_zero  <= (w_alu == '0);
        end
    end

    // Sticky bus contention flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict <= 1'b0;
        end else if (multi_drive(w_drv)) begin
            r_conflict <= 1'b1;
        end
    end

    sap_ram16x8 #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk         (clk),
        .rst         (rst),
        .i_prog_en   (prog_en),
        .i_prog_we   (prog_we),
        .i_prog_addr (prog_addr),
        .i_prog_data (prog_data),
        .i_we        (w_ram_ld),
        .i_addr      (r_mar),
        .i_wdata     (r_mdr),
        .o_rdata     (w_ram_rdata)
    );

    assign opcode       = r_ir[DATA_W-1 -: 4];
    assign out_val      = r_out;
    assign out_valid    = r_out_valid;
    assign carry        = r_carry;
    assign zero         = r_zero;
    assign bus_conflict = r_conflict;

endmodule
`default_nettype wire

// File: doc/sap_datapath.md
SAP_DATAPATH -- requirements
Module: sap_datapath

Interface
REQ-001 Parameter DATA_W, default 8, bus/register width.
REQ-002 Parameter ADDR_W, default 4, PC/MAR width and RAM depth 2^ADDR_W.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ctrl  input  15  control word from the control block; bit map per REQ-013.
REQ-007 opcode  output  4  IR[7:4], returned to the control block.
REQ-008 out_val  output  DATA_W  output register contents.
REQ-009 out_valid  output  1  one-cycle pulse, cycle after output register load.
REQ-010 carry, zero  output  1 each  registered ALU flags.
REQ-011 bus_conflict  output  1  sticky flag: more than one bus driver enabled.
REQ-012 prog_en, prog_we, prog_addr[ADDR_W-1:0], prog_data[DATA_W-1:0]  input  RAM programming port.

Function
REQ-013 ctrl bits SHALL be: 14 PC_INC, 13 PC_EN, 12 PC_LOAD, 11 MAR_ADDR_LOAD_N, 10 MAR_MEM_LOAD_N, 9 RAM_EN_N, 8 RAM_LOAD_N, 7 IR_LOAD_N, 6 IR_EN_N, 5 REGA_LOAD_N, 4 REGA_EN, 3 ADDER_SUB, 2 REGB_EN (ALU drive), 1 REGB_LOAD_N, 0 OUT_LOAD_N; _N bits active-low.
REQ-014 Bus drivers, combinational, priority PC_EN > RAM_EN_N > IR_EN_N > REGA_EN > REGB_EN: {0,PC}, RAM[MAR], {0,IR[3:0]}, A, ALU result; no driver -> bus = 0.
REQ-015 Two or more drivers in one cycle SHALL set bus_conflict at next edge; it stays set until reset.
REQ-016 PC: PC_LOAD -> PC <= bus[3:0]; else PC_INC -> PC <= PC+1 mod 16 (15 -> 0); load wins when both set.
REQ-017 MAR_ADDR_LOAD_N low -> MAR <= bus[3:0].
REQ-018 MAR_MEM_LOAD_N low -> MDR <= bus.
REQ-019 RAM_LOAD_N low -> RAM[MAR] <= MDR (MDR/MAR value before this edge).
REQ-020 RAM read asynchronous; RAM_EN_N and RAM_LOAD_N together SHALL drive old data, write at edge.
REQ-021 IR_LOAD_N low -> IR <= bus; REGA_LOAD_N low -> A <= bus; REGB_LOAD_N low -> B <= bus.
REQ-022 ALU combinational: ADDER_SUB=0 -> A+B, =1 -> A-B, modulo 2^DATA_W.
REQ-023 carry = add carry-out, or for subtract 1 when A >= B (no borrow); zero = result == 0.
REQ-024 Flags SHALL update only on an edge where REGB_EN=1 and REGA_LOAD_N=0; otherwise hold.
REQ-025 OUT_LOAD_N low -> out_val <= bus, out_valid = 1 for exactly the following cycle; back-to-back loads give consecutive pulses.
REQ-026 prog_en=1: ctrl treated as all-inactive (no loads, no drivers, no conflict); prog_we=1 -> RAM[prog_addr] <= prog_data each edge.
REQ-027 prog_en=0: prog_we ignored.
REQ-028 Latency: every register load/increment visible exactly one cycle after the enabling edge.

Reset
REQ-029 rst=1 SHALL immediately clear PC, MAR, MDR, IR, A, B, out_val, carry, zero, bus_conflict, out_valid to 0; opcode reads 0 (HLT).
REQ-030 RAM contents SHALL NOT be cleared by reset; a write in progress at reset assertion SHALL be discarded.
REQ-031 Reset mid-instruction SHALL leave no partial state; first edge after deassertion acts on ctrl normally.

Structure
REQ-032 Shared package sap_pkg SHALL hold ctrl bit indices, opcode constants (HLT 0, NOP 1, ADD 2, SUB 3, LDA 4, OUT 5, STA 6, JMP 7), DATA_W/ADDR_W defaults.
REQ-033 RAM SHALL be a sub-module sap_ram16x8 (async read, sync write, two write sources muxed by prog_en).

Verification
REQ-034 Program RAM[0]=0x4E, RAM[14]=0x05 via prog port; fetch ctrl sequence PC_EN+MAR_ADDR_LOAD_N, RAM_EN_N+IR_LOAD_N+PC_INC -> opcode=4, PC=1; IR_EN_N+MAR_ADDR_LOAD_N, RAM_EN_N+REGA_LOAD_N -> A=0x05.
REQ-035 A=0xF0, B=0x20, REGB_EN+REGA_LOAD_N, ADDER_SUB=0 -> A=0x10, carry=1, zero=0; A=0x05,B=0x05 SUB -> A=0, carry=1, zero=1; A=0x03,B=0x05 SUB -> A=0xFE, carry=0.
REQ-036 PC=15, PC_INC -> PC=0; PC_INC+PC_LOAD with bus=0x07 -> PC=7.
REQ-037 PC_EN and REGA_EN together -> bus shows {0,PC}, bus_conflict=1 next cycle, still 1 after 10 idle cycles, 0 after rst.
REQ-038 A=0x2A, REGA_EN+OUT_LOAD_N -> out_val=0x2A, out_valid high one cycle; MDR=0x33 via MAR_MEM_LOAD_N, MAR=9, RAM_LOAD_N -> RAM[9]=0x33.
REQ-039 Assert rst during fetch with A=0x55 -> all regs 0 asynchronously; RAM[0] still 0x4E after deassertion.
